// File: rtl/decode_stage.sv
// RV32I decode stage: register file, immediate/control generation and the ID/EX pipeline register.
// Also detects load-use hazards, flushes on a taken branch and emits RTI/RSI pulses to fetch.
module decode_stage #(
    parameter bit NOP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction_dec,
    input  logic [31:0] pc_dec,
    input  logic        branch,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall_fetch,
    output logic        rti,
    output logic        rsi,
    output logic [31:0] pc_idex,
    output logic [31:0] rs1_data_ex,
    output logic [31:0] rs2_data_ex,
    output logic [31:0] imm_ex,
    output logic [4:0]  rd_ex,
    output logic [3:0]  funct_ex,
    output logic [6:0]  opcode_ex,
    output logic        reg_write_ex,
    output logic        mem_read_ex,
    output logic        mem_write_ex,
    output logic        alu_src_imm_ex,
    output logic        branch_ex,
    output logic        jump_ex
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYS    = 7'b1111111;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;

    assign inst   = instruction_dec;
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    logic        legal, use_rs1, use_rs2, is_rti, is_rsi;
    logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_src_imm, dec_branch, dec_jump;
    logic [31:0] dec_imm;

    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        legal           = 1'b1;
        use_rs1         = 1'b0;
        use_rs2         = 1'b0;
        is_rti          = 1'b0;
        is_rsi          = 1'b0;
        dec_reg_write   = 1'b0;
        dec_mem_read    = 1'b0;
        dec_mem_write   = 1'b0;
        dec_alu_src_imm = 1'b1;
        dec_branch      = 1'b0;
        dec_jump        = 1'b0;
        dec_imm         = '0;
        unique case (opcode)
            OP_R: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec_reg_write = 1'b1; dec_alu_src_imm = 1'b0;
            end
            OP_I_ALU, OP_JALR: begin
                use_rs1 = 1'b1; dec_reg_write = 1'b1; dec_jump = (opcode == OP_JALR);
                dec_imm = {{20{inst[31]}}, inst[31:20]};
            end
            OP_LOAD: begin
                use_rs1 = 1'b1; dec_reg_write = 1'b1; dec_mem_read = 1'b1;
                dec_imm = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec_mem_write = 1'b1;
                dec_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec_branch = 1'b1; dec_alu_src_imm = 1'b0;
                dec_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_JAL: begin
                dec_reg_write = 1'b1; dec_jump = 1'b1;
                dec_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_reg_write = 1'b1;
                dec_imm = {inst[31:12], 12'b0};
            end
            OP_SYS: begin
                is_rti = (funct3 == 3'b000);
                is_rsi = (funct3 == 3'b001);
                legal  = is_rti | is_rsi;
            end
            default: legal = 1'b0;
        endcase
    end

    logic [31:0] regs [32];

    // NOTE: the register file is cleared by reset, so it is built from flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    function automatic logic [31:0] read_reg(input logic [4:0] idx, input logic [31:0] stored);
        if (idx == 5'd0)                return '0;
        else if (wb_we && wb_rd == idx) return wb_data;
        else                            return stored;
    endfunction

    logic [31:0] rs1_val, rs2_val;
    assign rs1_val = read_reg(rs1, regs[rs1]);
    assign rs2_val = read_reg(rs2, regs[rs2]);

    assign stall_fetch = mem_read_ex && (rd_ex != 5'd0) && !branch &&
                         ((use_rs1 && rs1 == rd_ex) || (use_rs2 && rs2 == rd_ex));

    logic load_bubble;
    assign load_bubble = branch || stall_fetch || (!legal && NOP_ON_ILLEGAL);

    // NOTE: pipeline state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_idex <= '0; rs1_data_ex <= '0; rs2_data_ex <= '0; imm_ex <= '0;
            rd_ex <= '0; funct_ex <= '0; opcode_ex <= '0;
            reg_write_ex <= 1'b0; mem_read_ex <= 1'b0; mem_write_ex <= 1'b0;
            alu_src_imm_ex <= 1'b0; branch_ex <= 1'b0; jump_ex <= 1'b0;
            rti <= 1'b0; rsi <= 1'b0;
        end else begin
            pc_idex <= pc_dec;
            if (load_bubble) begin
                rs1_data_ex <= '0; rs2_data_ex <= '0; imm_ex <= '0;
                rd_ex <= '0; funct_ex <= '0; opcode_ex <= '0;
                reg_write_ex <= 1'b0; mem_read_ex <= 1'b0; mem_write_ex <= 1'b0;
                alu_src_imm_ex <= 1'b0; branch_ex <= 1'b0; jump_ex <= 1'b0;
                rti <= 1'b0; rsi <= 1'b0;
            end else begin
                rs1_data_ex    <= rs1_val;
                rs2_data_ex    <= rs2_val;
                imm_ex         <= dec_imm;
                rd_ex          <= rd;
                funct_ex       <= {inst[30], funct3};
                opcode_ex      <= opcode;
                reg_write_ex   <= dec_reg_write & legal;
                mem_read_ex    <= dec_mem_read;
                mem_write_ex   <= dec_mem_write;
                alu_src_imm_ex <= dec_alu_src_imm & legal;
                branch_ex      <= dec_branch;
                jump_ex        <= dec_jump;
                rti            <= is_rti;
                rsi            <= is_rsi;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table of instruction vectors with expected ID/EX contents,
// plus a mid-operation reset sequence.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction_dec = 32'h13;
    logic [31:0] pc_dec = '0;
    logic        branch = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        stall_fetch, rti, rsi;
    logic [31:0] pc_idex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]  rd_ex;
    logic [3:0]  funct_ex;
    logic [6:0]  opcode_ex;
    logic        reg_write_ex, mem_read_ex, mem_write_ex, alu_src_imm_ex, branch_ex, jump_ex;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .instruction_dec(instruction_dec), .pc_dec(pc_dec),
        .branch(branch), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_fetch(stall_fetch), .rti(rti), .rsi(rsi), .pc_idex(pc_idex),
        .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
        .rd_ex(rd_ex), .funct_ex(funct_ex), .opcode_ex(opcode_ex),
        .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .alu_src_imm_ex(alu_src_imm_ex), .branch_ex(branch_ex), .jump_ex(jump_ex)
    );

    always #5 clk = ~clk;

    // ctrl = {reg_write, mem_read, mem_write, alu_src_imm, branch, jump}
    typedef struct {
        logic [31:0] instr;
        logic        br;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        stall;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [5:0]  ctrl;
        logic        rti;
        logic        rsi;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [5:0]  ctrl;
        logic        rti;
        logic        rsi;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v, input logic [31:0] pc);
        exp_t e, got;
        @(negedge clk);
        instruction_dec = v.instr; pc_dec = pc; branch = v.br;
        wb_we = v.we; wb_rd = v.wrd; wb_data = v.wdata;
        #1;
        check({tag, "_stall"}, {31'b0, stall_fetch}, {31'b0, v.stall});
        e = '{pc, v.rs1d, v.rs2d, v.imm, v.rd, v.ctrl, v.rti, v.rsi};
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({tag, "_pc"},   pc_idex, got.pc);
        check({tag, "_rs1"},  rs1_data_ex, got.rs1d);
        check({tag, "_rs2"},  rs2_data_ex, got.rs2d);
        check({tag, "_imm"},  imm_ex, got.imm);
        check({tag, "_rd"},   {27'b0, rd_ex}, {27'b0, got.rd});
        check({tag, "_ctrl"}, {26'b0, reg_write_ex, mem_read_ex, mem_write_ex, alu_src_imm_ex, branch_ex, jump_ex},
                              {26'b0, got.ctrl});
        check({tag, "_rti"},  {31'b0, rti}, {31'b0, got.rti});
        check({tag, "_rsi"},  {31'b0, rsi}, {31'b0, got.rsi});
    endtask

    initial begin
        //          instr         br   we   wrd    wdata         stall rs1d          rs2d         imm           rd     ctrl       rti  rsi
        vecs[0]  = '{32'h00000013, 1'b0, 1'b1, 5'd5, 32'h1234,     1'b0, 32'h0,        32'h0,       32'h0,        5'd0,  6'b100100, 1'b0, 1'b0};
        vecs[1]  = '{32'h00000013, 1'b0, 1'b1, 5'd1, 32'h11,       1'b0, 32'h0,        32'h0,       32'h0,        5'd0,  6'b100100, 1'b0, 1'b0};
        vecs[2]  = '{32'h00000013, 1'b0, 1'b1, 5'd2, 32'h100,      1'b0, 32'h0,        32'h0,       32'h0,        5'd0,  6'b100100, 1'b0, 1'b0};
        vecs[3]  = '{32'h000281B3, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h1234,     32'h0,       32'h0,        5'd3,  6'b100000, 1'b0, 1'b0};
        vecs[4]  = '{32'hFFC12383, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h100,      32'h0,       32'hFFFFFFFC, 5'd7,  6'b110100, 1'b0, 1'b0};
        vecs[5]  = '{32'h00138433, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h0,        32'h0,       32'h0,        5'd0,  6'b000000, 1'b0, 1'b0};
        vecs[6]  = '{32'h00138433, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h11,      32'h0,        5'd8,  6'b100000, 1'b0, 1'b0};
        vecs[7]  = '{32'hFFC12383, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h100,      32'h0,       32'hFFFFFFFC, 5'd7,  6'b110100, 1'b0, 1'b0};
        vecs[8]  = '{32'h00138433, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,       32'h0,        5'd0,  6'b000000, 1'b0, 1'b0};
        vecs[9]  = '{32'h00130093, 1'b0, 1'b1, 5'd6, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'h11,      32'h1,        5'd1,  6'b100100, 1'b0, 1'b0};
        vecs[10] = '{32'h00100093, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0,        32'h11,      32'h1,        5'd1,  6'b100100, 1'b0, 1'b0};
        vecs[11] = '{32'h00512423, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,       32'h0,        5'd0,  6'b000000, 1'b0, 1'b0};
        vecs[12] = '{32'h00512423, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h100,      32'h1234,    32'h8,        5'd8,  6'b001100, 1'b0, 1'b0};
        vecs[13] = '{32'h0000007F, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,       32'h0,        5'd0,  6'b000100, 1'b1, 1'b0};
        vecs[14] = '{32'h00000013, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,       32'h0,        5'd0,  6'b100100, 1'b0, 1'b0};
        vecs[15] = '{32'h0000107F, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,       32'h0,        5'd0,  6'b000100, 1'b0, 1'b1};
        vecs[16] = '{32'h00000013, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,       32'h0,        5'd0,  6'b100100, 1'b0, 1'b0};
        vecs[17] = '{32'h0000007F, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,       32'h0,        5'd0,  6'b000000, 1'b0, 1'b0};
        vecs[18] = '{32'h00000013, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,       32'h0,        5'd0,  6'b100100, 1'b0, 1'b0};
        vecs[19] = '{32'hFE000CE3, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,       32'hFFFFFFF8, 5'd25, 6'b000010, 1'b0, 1'b0};
        vecs[20] = '{32'h0000000B, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,       32'h0,        5'd0,  6'b000000, 1'b0, 1'b0};
        vecs[21] = '{32'h123454B7, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,       32'h12345000, 5'd9,  6'b100100, 1'b0, 1'b0};
        vecs[22] = '{32'h010000EF, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,       32'h10,       5'd1,  6'b100101, 1'b0, 1'b0};

        // Reset state while rst_n is low.
        #12;
        check("reset_pc",   pc_idex, 32'h0);
        check("reset_rd",   {27'b0, rd_ex}, 32'h0);
        check("reset_ctrl", {26'b0, reg_write_ex, mem_read_ex, mem_write_ex, alu_src_imm_ex, branch_ex, jump_ex}, 32'h0);
        check("reset_stall", {31'b0, stall_fetch}, 32'h0);
        check("reset_pulse", {30'b0, rti, rsi}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++)
            apply($sformatf("v%0d", i), vecs[i], 32'h1000 + 32'(i) * 4);

        // Mid-operation reset: in-flight load is discarded and the register file is cleared.
        apply("mr_load", vecs[7], 32'h2000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_mem_read", {31'b0, mem_read_ex}, 32'h0);
        check("mr_rd", {27'b0, rd_ex}, 32'h0);
        check("mr_imm", imm_ex, 32'h0);
        check("mr_stall", {31'b0, stall_fetch}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("mr_add", '{32'h000281B3, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd3, 6'b100000, 1'b0, 1'b0},
              32'h2004);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
